// File: rtl/pcie_link_mon.sv
// PCIe link monitor: registers link-up/LTSSM, debounces link-up into a stable flag,
// counts link-loss events and drives a down/training/stable status LED.
module pcie_link_mon #(
    parameter int unsigned DEBOUNCE_CYC = 1024,
    parameter logic [5:0]  L0_CODE      = 6'h11,
    parameter int unsigned BLINK_BIT    = 21,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             core_clk,
    input  logic             core_rst_n,
    input  logic             link_up_i,
    input  logic [5:0]       ltssm_state_i,
    input  logic             clr_cnt_i,
    output logic             link_stable_o,
    output logic             link_led_o,
    output logic [CNT_W-1:0] link_down_cnt_o,
    output logic             link_lost_pulse_o,
    output logic [2:0]       fsm_state_o
);

    localparam int unsigned       DEB_W    = $clog2(DEBOUNCE_CYC);
    localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);

    typedef enum logic [2:0] {
        ST_DOWN   = 3'd0,
        ST_TRAIN  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_UP     = 3'd3,
        ST_LOST   = 3'd4
    } state_t;

    state_t           state_q;
    logic [DEB_W-1:0] deb_cnt_q;
    logic             up_r;
    logic [5:0]       ltssm_r;
    logic [23:0]      blink_cnt_q;
    logic             led_q;
    logic [CNT_W-1:0] down_cnt_q;
    logic             good;
    logic             idle;
    logic             lost_entry;

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            up_r    <= 1'b0;
            ltssm_r <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            up_r    <= link_up_i;
            ltssm_r <= ltssm_state_i;
        end
    end

    assign good       = up_r && (ltssm_r == L0_CODE);
    assign idle       = (ltssm_r == 6'd0);
    assign lost_entry = (state_q == ST_UP) && !good;

    // Any bad cycle in SETTLE leaves the state, so debounce restarts from 0 on re-entry.
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            state_q   <= ST_DOWN;
            deb_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_DOWN: begin
                    if (!idle) state_q <= ST_TRAIN;
                end
                ST_TRAIN: begin
                    if (good) begin
                        state_q   <= ST_SETTLE;
                        deb_cnt_q <= '0;
                    end else if (idle) begin
                        state_q <= ST_DOWN;
                    end
                end
                ST_SETTLE: begin
                    if (!good) begin
                        state_q <= idle ? ST_DOWN : ST_TRAIN;
                    end else if (deb_cnt_q == DEB_LAST) begin
                        state_q <= ST_UP;
                    end else begin
                        deb_cnt_q <= deb_cnt_q + 1'b1;
                    end
                end
                ST_UP: begin
                    if (!good) state_q <= ST_LOST;
                end
                ST_LOST: begin
                    state_q <= idle ? ST_DOWN : ST_TRAIN;
                end
                default: begin
                    state_q <= ST_DOWN;
                end
            endcase
        end
    end

    // A clear coinciding with a loss keeps that loss, so the result is 1 rather than 0.
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            down_cnt_q <= '0;
        end else if (clr_cnt_i) begin
            down_cnt_q <= lost_entry ? CNT_W'(1) : '0;
        end else if (lost_entry && (down_cnt_q != '1)) begin
            down_cnt_q <= down_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            blink_cnt_q <= '0;
            led_q       <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_q + 24'd1;
            case (state_q)
                ST_TRAIN, ST_SETTLE: led_q <= blink_cnt_q[BLINK_BIT];
                ST_UP:               led_q <= 1'b1;
                default:             led_q <= 1'b0;
            endcase
        end
    end

    assign link_stable_o     = (state_q == ST_UP);
    assign link_lost_pulse_o = (state_q == ST_LOST);
    assign fsm_state_o       = state_q;
    assign link_down_cnt_o   = down_cnt_q;
    assign link_led_o        = led_q;

endmodule

// File: tb/tb_pcie_link_mon.sv
// Scoreboard bench for pcie_link_mon: stimulus queues expected stable/lost events,
// a negedge monitor pops and compares them; a narrow-counter instance covers saturation.
module tb_pcie_link_mon;

    typedef enum logic [1:0] {EV_RISE = 2'd1, EV_FALL = 2'd2, EV_LOST = 2'd3} ev_kind_t;
    typedef struct packed {
        ev_kind_t    kind;
        logic [31:0] cyc;
        logic [15:0] cnt;
    } ev_t;

    ev_t sb_q[$];

    logic        core_clk   = 1'b0;
    logic        core_rst_n = 1'b0;
    logic        link_up    = 1'b0;
    logic [5:0]  ltssm      = 6'd0;
    logic        clr_cnt    = 1'b0;
    logic        link_stable;
    logic        link_led;
    logic [15:0] link_down_cnt;
    logic        link_lost_pulse;
    logic [2:0]  fsm_state;

    logic        s_up    = 1'b0;
    logic [5:0]  s_ltssm = 6'd0;
    logic        s_clr   = 1'b0;
    logic        s_stable;
    logic        s_led;
    logic [3:0]  s_cnt;
    logic        s_pulse;
    logic [2:0]  s_state;

    int cyc      = 0;
    int rel_cyc  = 0;
    int n_pass   = 0;
    int n_total  = 0;
    int s_pulses = 0;
    logic prev_stable = 1'b0;

    pcie_link_mon #(
        .DEBOUNCE_CYC(16), .L0_CODE(6'h11), .BLINK_BIT(3), .CNT_W(16)
    ) dut (
        .core_clk(core_clk), .core_rst_n(core_rst_n),
        .link_up_i(link_up), .ltssm_state_i(ltssm), .clr_cnt_i(clr_cnt),
        .link_stable_o(link_stable), .link_led_o(link_led),
        .link_down_cnt_o(link_down_cnt), .link_lost_pulse_o(link_lost_pulse),
        .fsm_state_o(fsm_state)
    );

    // Narrow counter so all-ones is reachable in a few hundred cycles.
    pcie_link_mon #(
        .DEBOUNCE_CYC(2), .L0_CODE(6'h11), .BLINK_BIT(3), .CNT_W(4)
    ) dut_sat (
        .core_clk(core_clk), .core_rst_n(core_rst_n),
        .link_up_i(s_up), .ltssm_state_i(s_ltssm), .clr_cnt_i(s_clr),
        .link_stable_o(s_stable), .link_led_o(s_led),
        .link_down_cnt_o(s_cnt), .link_lost_pulse_o(s_pulse),
        .fsm_state_o(s_state)
    );

    always #5 core_clk = ~core_clk;
    always @(posedge core_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    endtask

    task automatic expect_ev(input ev_kind_t k, input int c, input int cnt);
        ev_t e;
        e.kind = k;
        e.cyc  = 32'(c);
        e.cnt  = 16'(cnt);
        sb_q.push_back(e);
    endtask

    task automatic observe(input ev_kind_t k);
        ev_t got;
        ev_t exp;
        got.kind = k;
        got.cyc  = 32'(cyc);
        got.cnt  = link_down_cnt;
        n_total++;
        if (sb_q.size() == 0) begin
            $display("FAIL sb_unexpected: got kind=%0d cyc=%0d cnt=%0d, expected no event",
                     int'(got.kind), got.cyc, got.cnt);
        end else begin
            exp = sb_q.pop_front();
            if (got == exp) n_pass++;
            else $display("FAIL sb_event: got kind=%0d cyc=%0d cnt=%0d, expected kind=%0d cyc=%0d cnt=%0d",
                          int'(got.kind), got.cyc, got.cnt, int'(exp.kind), exp.cyc, exp.cnt);
        end
    endtask

    always @(negedge core_clk) begin
        if (link_stable !== prev_stable) observe(link_stable ? EV_RISE : EV_FALL);
        if (link_lost_pulse === 1'b1) observe(EV_LOST);
        prev_stable = link_stable;
        if (s_pulse === 1'b1) s_pulses++;
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge core_clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"},  fsm_state, 0);
        check({tag, "_stable"}, link_stable, 0);
        check({tag, "_led"},    link_led, 0);
        check({tag, "_cnt"},    link_down_cnt, 0);
        check({tag, "_pulse"},  link_lost_pulse, 0);
    endtask

    initial begin
        int e, f, g, h, r, k;

        #2;
        check_reset_outputs("por");
        step(3);
        core_rst_n = 1'b1;
        rel_cyc    = cyc;

        // Idle link for 100 cycles: everything stays at reset values.
        step(100);
        check_reset_outputs("idle");

        // Bring-up from DOWN: inputs sampled at e+1, TRAIN e+2, SETTLE e+3, UP e+19.
        e = cyc;
        ltssm   = 6'h11;
        link_up = 1'b1;
        expect_ev(EV_RISE, e + 19, 0);
        step(3);
        for (int c = e + 4; c <= e + 19; c++) begin
            step(1);
            check("led_blink", link_led, 64'(((c - 1 - rel_cyc) >> 3) & 1));
        end
        step(1);
        check("led_solid", link_led, 1);

        // Recovery entry from UP: sampled f+1, LOST at f+2, TRAIN at f+3.
        step(2);
        f = cyc;
        ltssm = 6'h0F;
        expect_ev(EV_FALL, f + 2, 1);
        expect_ev(EV_LOST, f + 2, 1);
        step(3);
        check("lost_to_train", fsm_state, 1);
        check("led_after_loss", link_led, 0);
        check("cnt_after_loss", link_down_cnt, 1);

        // One-cycle glitch while SETTLE holds count 10 sends the FSM back to TRAIN.
        step(1);
        g = cyc;
        ltssm = 6'h11;
        step(11);
        link_up = 1'b0;
        step(1);
        check("settle_before_glitch", fsm_state, 2);
        link_up = 1'b1;
        step(1);
        check("glitch_to_train", fsm_state, 1);
        expect_ev(EV_RISE, g + 30, 1);
        step(18);

        // Clear coinciding with a loss entry leaves the count at 1, not 0 or 2.
        h = cyc;
        ltssm = 6'h0F;
        step(1);
        clr_cnt = 1'b1;
        expect_ev(EV_FALL, h + 2, 1);
        expect_ev(EV_LOST, h + 2, 1);
        step(1);
        clr_cnt = 1'b0;
        check("clr_coincident", link_down_cnt, 1);

        // Saturation on the 4-bit instance.
        s_up    = 1'b1;
        s_ltssm = 6'h0F;
        step(3);
        for (int i = 1; i <= 17; i++) begin
            s_ltssm = 6'h11;
            step(6);
            s_ltssm = 6'h0F;
            step(4);
            if (i == 15) check("sat_reach_max", s_cnt, 15);
        end
        check("sat_hold_max", s_cnt, 15);
        check("sat_pulse_count", s_pulses, 17);
        s_ltssm = 6'h11;
        step(6);
        s_ltssm = 6'h0F;
        step(1);
        s_clr = 1'b1;
        step(1);
        s_clr = 1'b0;
        check("sat_clr_coincident", s_cnt, 1);
        step(2);
        s_clr = 1'b1;
        step(1);
        s_clr = 1'b0;
        check("sat_clr_plain", s_cnt, 0);

        // Asynchronous reset mid-SETTLE.
        ltssm = 6'h11;
        step(8);
        check("pre_reset_settle", fsm_state, 2);
        #2 core_rst_n = 1'b0;
        #1 check_reset_outputs("rst_settle");
        step(2);
        core_rst_n = 1'b1;
        r = cyc;
        expect_ev(EV_RISE, r + 19, 0);
        step(20);

        k = cyc;
        ltssm = 6'h0F;
        expect_ev(EV_FALL, k + 2, 1);
        expect_ev(EV_LOST, k + 2, 1);
        step(4);
        ltssm = 6'h11;
        expect_ev(EV_RISE, k + 22, 1);
        step(23);

        // Asynchronous reset mid-UP: stable drops before the next edge.
        check("pre_reset_up", fsm_state, 3);
        expect_ev(EV_FALL, cyc, 0);
        #2 core_rst_n = 1'b0;
        #1 check_reset_outputs("rst_up");
        step(3);
        core_rst_n = 1'b1;
        step(5);

        check("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
